// File: rtl/axis_ps2_tx.sv
// axis_ps2_tx
// Host-to-device PS/2 transmitter. Takes one command byte from an AXI-stream
// slave port and sends it to the device with the PS/2 host-to-device protocol.
// It inhibits the bus, issues the request-to-send and then shifts data out on
// the device-generated clock. When the frame ends it reports the device ACK,
// a missing ACK or a timeout.
//
// Ports
//   axis_aclk_i      in   single clock
//   axis_aresetn_i   in   synchronous active-low reset
//   s_axis_tvalid_i  in   command byte valid
//   s_axis_tready_o  out  ready to accept a byte (IDLE only, out of reset)
//   s_axis_tdata_i   in   command byte
//   ps2_clk_i        in   PS/2 clock pin (asynchronous)
//   ps2_data_i       in   PS/2 data pin (asynchronous)
//   ps2_clk_oe_o     out  1 = pull PS/2 clock low
//   ps2_data_oe_o    out  1 = pull PS/2 data low
//   busy_o           out  any state other than IDLE
//   ack_o            out  1-cycle pulse: frame done and device ACK seen
//   err_o            out  1-cycle pulse: frame done without ACK, or timeout
//   state_o          out  current FSM state (debug)
//
// Handshake: a byte transfers on a rising edge where s_axis_tvalid_i and
// s_axis_tready_o are both high. tready does not depend on tvalid. A byte that
// is offered while the block is busy stays pending until the block is IDLE.
module axis_ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       axis_aclk_i,
  input  logic       axis_aresetn_i,
  input  logic       s_axis_tvalid_i,
  output logic       s_axis_tready_o,
  input  logic [7:0] s_axis_tdata_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       busy_o,
  output logic       ack_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;        // inhibit length, then cycles since clock release
  logic [8:0]      shift_q;      // {parity, byte}, LSB goes out first
  logic [3:0]      fall_cnt_q;   // device clock falls seen so far in SEND
  logic            data_bit_q;   // 1 = hold data low during SEND
  logic            ack_ok_q;
  logic            clk_meta_q, clk_sync_q, clk_prev_q;
  logic            data_meta_q, data_sync_q;

  logic            fall;
  logic            timeout;
  logic            accept;

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign timeout = ((state_q == S_SEND) || (state_q == S_WAIT_IDLE)) &&
                   (cnt_q == CW'(TIMEOUT_CYCLES));
  assign accept  = s_axis_tvalid_i & s_axis_tready_o;
  assign busy_o  = (state_q != S_IDLE);
  assign state_o = state_q;

  always_comb begin
    state_d         = state_q;
    s_axis_tready_o = 1'b0;
    ps2_clk_oe_o    = 1'b0;
    ps2_data_oe_o   = 1'b0;
    ack_o           = 1'b0;
    err_o           = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Gated by reset so tready reads 0 while reset is held.
        s_axis_tready_o = axis_aresetn_i;
        if (s_axis_tvalid_i && axis_aresetn_i) state_d = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2_clk_oe_o = 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) state_d = S_REQ;
      end
      S_REQ: begin
        ps2_clk_oe_o  = 1'b1;
        ps2_data_oe_o = 1'b1;
        state_d       = S_SEND;
      end
      S_SEND: begin
        // Timeout wins over a fall arriving in the same cycle and frees
        // the data line immediately.
        if (timeout) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          ps2_data_oe_o = data_bit_q;
          if (fall && (fall_cnt_q == 4'd10)) state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (timeout) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else if (clk_sync_q && data_sync_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ack_o   = ack_ok_q;
        err_o   = ~ack_ok_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk_i) begin
    if (!axis_aresetn_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      fall_cnt_q  <= '0;
      data_bit_q  <= 1'b0;
      ack_ok_q    <= 1'b0;
      // Idle bus level is high; starting the synchronisers there avoids a
      // phantom fall straight out of reset.
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
      state_q     <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shift_q    <= {~^s_axis_tdata_i, s_axis_tdata_i};
            cnt_q      <= '0;
            fall_cnt_q <= '0;
          end
        end
        S_INHIBIT: cnt_q <= cnt_q + 1'b1;
        S_REQ: begin
          // The clock is released as REQ exits; the first SEND cycle counts as 1.
          cnt_q      <= CW'(1);
          data_bit_q <= 1'b1;
        end
        S_SEND: begin
          cnt_q <= cnt_q + 1'b1;
          if (fall && !timeout) begin
            fall_cnt_q <= fall_cnt_q + 1'b1;
            if (fall_cnt_q < 4'd9) begin
              data_bit_q <= ~shift_q[0];
              shift_q    <= {1'b0, shift_q[8:1]};
            end else if (fall_cnt_q == 4'd9) begin
              data_bit_q <= 1'b0;
            end else begin
              ack_ok_q <= ~data_sync_q;
            end
          end
        end
        S_WAIT_IDLE: cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_ps2_tx.sv
// Testbench for axis_ps2_tx. A behavioural PS/2 device drives open-drain
// clock/data lines that are combined with the DUT pull-low enables. The device
// clock is sped up (half period H cycles) to keep frames short.
module tb_axis_ps2_tx;

  localparam int INH = 50;
  localparam int TMO = 2000;
  localparam int H   = 20;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       tvalid = 1'b0;
  logic       tready;
  logic [7:0] tdata = 8'h00;
  logic       ps2_clk, ps2_data;
  logic       clk_oe, data_oe;
  logic       busy, ack, err;
  logic [2:0] state;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  assign ps2_clk  = ~clk_oe & dev_clk;
  assign ps2_data = ~data_oe & dev_data;

  axis_ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .axis_aclk_i    (clk),
    .axis_aresetn_i (aresetn),
    .s_axis_tvalid_i(tvalid),
    .s_axis_tready_o(tready),
    .s_axis_tdata_i (tdata),
    .ps2_clk_i      (ps2_clk),
    .ps2_data_i     (ps2_data),
    .ps2_clk_oe_o   (clk_oe),
    .ps2_data_oe_o  (data_oe),
    .busy_o         (busy),
    .ack_o          (ack),
    .err_o          (err),
    .state_o        (state)
  );

  // Clock/reset block
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_cnt = 0, err_cnt = 0, both_cnt = 0;
  int ack_cyc = 0, err_cyc = 0;
  int inh_run = 0, last_inh = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse / inhibit monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (ack) begin ack_cnt++; ack_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (ack && err) both_cnt++;
    if (clk_oe && !data_oe) inh_run++;
    else if (inh_run != 0) begin last_inh = inh_run; inh_run = 0; end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Driver tasks. All are entered and left at a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input bit keep, output int acc, output bit ok);
    tdata  = b;
    tvalid = 1'b1;
    ok     = 1'b0;
    acc    = 0;
    for (int i = 0; i < 5000; i++) begin
      if (tready) begin acc = cyc; ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if (!keep || !ok) tvalid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (clk_oe && data_oe) begin ok = 1'b1; break; end
    end
  endtask

  // Device BFM: clocks 11 falls, samples the line at each rise for falls
  // 1..10, drives ACK at fall 11. stop_after>0 returns with clock low.
  task automatic dev_frame(input bit give_ack, input int stop_after,
                           output logic [9:0] seen, output bit ok);
    seen = '0;
    wait_req(ok);
    if (!ok) return;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      if (i == 10) dev_data = give_ack ? 1'b0 : 1'b1;
      repeat (H) @(negedge clk);
      if (i + 1 == stop_after) return;
      if (i < 10) seen[i] = ps2_data;
      dev_clk = 1'b1;
      if (i == 10) dev_data = 1'b1;
    end
    repeat (H) @(negedge clk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tready !== 1'b0) begin n_bad++; $display("FAIL reset_tready got=%b exp=0", tready); end
    n_cmp++; if ({clk_oe, data_oe} !== 2'b00) begin n_bad++; $display("FAIL reset_oe got=%b exp=00", {clk_oe, data_oe}); end
    n_cmp++; if ({busy, ack, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {busy, ack, err}); end
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    aresetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (tready !== 1'b1) begin n_bad++; $display("FAIL post_reset_tready got=%b exp=1", tready); end
  endtask

  task automatic test_frame(input logic [7:0] b, input logic [9:0] exp_seen, input string nm);
    int a0, e0, acc;
    bit ok;
    logic [9:0] seen;
    a0 = ack_cnt; e0 = err_cnt;
    send_byte(b, 1'b0, acc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_accept got=none exp=accepted", nm); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy got=%b exp=1", nm, busy); end
    dev_frame(1'b1, 0, seen, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_req got=none exp=request", nm); end
    n_cmp++; if (seen !== exp_seen) begin n_bad++; $display("FAIL %s_bits got=%h exp=%h", nm, seen, exp_seen); end
    n_cmp++; if (ack_cnt !== a0 + 1) begin n_bad++; $display("FAIL %s_ack got=%0d exp=%0d", nm, ack_cnt - a0, 1); end
    n_cmp++; if (err_cnt !== e0) begin n_bad++; $display("FAIL %s_err got=%0d exp=0", nm, err_cnt - e0); end
    n_cmp++; if (tready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL %s_idle got=tready%b busy%b exp=tready1 busy0", nm, tready, busy); end
  endtask

  task automatic test_no_ack();
    int a0, e0, acc;
    bit ok;
    logic [9:0] seen;
    a0 = ack_cnt; e0 = err_cnt;
    send_byte(8'hED, 1'b0, acc, ok);
    dev_frame(1'b0, 0, seen, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL noack_req got=none exp=request"); end
    n_cmp++; if (err_cnt !== e0 + 1) begin n_bad++; $display("FAIL noack_err got=%0d exp=1", err_cnt - e0); end
    n_cmp++; if (ack_cnt !== a0) begin n_bad++; $display("FAIL noack_ack got=%0d exp=0", ack_cnt - a0); end
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL noack_state got=%0d exp=0", state); end
  endtask

  task automatic test_timeout();
    int a0, e0, acc, r, e;
    bit ok, seen_err;
    logic oe_at_err;
    a0 = ack_cnt; e0 = err_cnt;
    send_byte(8'hF4, 1'b0, acc, ok);
    wait_req(ok);
    r = cyc;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_req got=none exp=request"); end
    seen_err = 1'b0; e = 0; oe_at_err = 1'b1;
    for (int i = 0; i < TMO + 100; i++) begin
      @(negedge clk);
      if (err) begin seen_err = 1'b1; e = cyc; oe_at_err = clk_oe | data_oe; break; end
    end
    n_cmp++; if (!seen_err) begin n_bad++; $display("FAIL tmo_pulse got=none exp=err"); end
    n_cmp++; if (e - r !== TMO) begin n_bad++; $display("FAIL tmo_delay got=%0d exp=%0d", e - r, TMO); end
    n_cmp++; if (oe_at_err !== 1'b0) begin n_bad++; $display("FAIL tmo_release got=%b exp=0", oe_at_err); end
    @(negedge clk);
    n_cmp++; if ({clk_oe, data_oe, busy} !== 3'b000) begin n_bad++; $display("FAIL tmo_idle got=%b exp=000", {clk_oe, data_oe, busy}); end
    n_cmp++; if (err_cnt !== e0 + 1 || ack_cnt !== a0) begin n_bad++; $display("FAIL tmo_counts got=err%0d ack%0d exp=err1 ack0", err_cnt - e0, ack_cnt - a0); end
  endtask

  task automatic test_reset_mid_frame();
    int a0, e0, acc;
    bit ok;
    logic [9:0] seen;
    a0 = ack_cnt; e0 = err_cnt;
    send_byte(8'hFF, 1'b0, acc, ok);
    dev_frame(1'b1, 5, seen, ok);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    aresetn = 1'b0;
    @(negedge clk);
    n_cmp++; if ({clk_oe, data_oe, busy} !== 3'b000) begin n_bad++; $display("FAIL midrst_release got=%b exp=000", {clk_oe, data_oe, busy}); end
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (ack_cnt !== a0 || err_cnt !== e0) begin n_bad++; $display("FAIL midrst_pulses got=ack%0d err%0d exp=0 0", ack_cnt - a0, err_cnt - e0); end
    test_frame(8'hFF, 10'h3FF, "ff_after_rst");
  endtask

  task automatic test_back_to_back();
    int a0, acc1, acc2, ack1, inh1, inh2;
    bit ok1, ok2, okd1, okd2;
    logic [9:0] s1, s2;
    a0 = ack_cnt; ack1 = 0; inh1 = 0; inh2 = 0;
    fork
      begin
        send_byte(8'h01, 1'b1, acc1, ok1);
        send_byte(8'h02, 1'b0, acc2, ok2);
      end
      begin
        dev_frame(1'b1, 0, s1, okd1);
        ack1 = ack_cyc;
        inh1 = last_inh;
        dev_frame(1'b1, 0, s2, okd2);
        inh2 = last_inh;
      end
    join
    n_cmp++; if (!(ok1 && ok2 && okd1 && okd2)) begin n_bad++; $display("FAIL b2b_flow got=%b%b%b%b exp=1111", ok1, ok2, okd1, okd2); end
    n_cmp++; if (s1 !== 10'h201) begin n_bad++; $display("FAIL b2b_bits1 got=%h exp=201", s1); end
    n_cmp++; if (s2 !== 10'h202) begin n_bad++; $display("FAIL b2b_bits2 got=%h exp=202", s2); end
    n_cmp++; if (acc2 !== ack1 + 1) begin n_bad++; $display("FAIL b2b_accept2 got=%0d exp=%0d", acc2, ack1 + 1); end
    n_cmp++; if (inh1 !== INH) begin n_bad++; $display("FAIL b2b_inhibit1 got=%0d exp=%0d", inh1, INH); end
    n_cmp++; if (inh2 !== INH) begin n_bad++; $display("FAIL b2b_inhibit2 got=%0d exp=%0d", inh2, INH); end
    n_cmp++; if (ack_cnt !== a0 + 2) begin n_bad++; $display("FAIL b2b_acks got=%0d exp=2", ack_cnt - a0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame(8'hED, 10'h3ED, "ed");
    test_frame(8'hF4, 10'h2F4, "f4");
    test_no_ack();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL ack_err_overlap got=%0d exp=0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
